press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold time in clk cycles that classifies a press as long (min 2).
REQ-002 Parameter DBL_GAP_CYCLES, default 12_500_000, maximum release-to-repress gap in clk cycles for a double click (min 2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pb_debounced  input  1  debounced, clk-synchronous button level; 1 = pressed.
REQ-006 press_pulse  output  1  one-cycle pulse on every press (rising edge of pb_debounced).
REQ-007 short_press  output  1  one-cycle pulse: press released before LONG_CYCLES.
REQ-008 long_press  output  1  one-cycle pulse: press held for LONG_CYCLES.
REQ-009 double_click  output  1  one-cycle pulse: second press within gap; tied 0 when feature is compiled out.
REQ-010 held  output  1  level, high while FSM is in LONG_HELD.

Function
REQ-011 All outputs SHALL be registered; the "cycle after edge k" is the cycle between clk edges k and k+1.
REQ-012 The block SHALL keep a registered prev copy of pb_debounced; rise = pb_debounced & ~prev; fall = ~pb_debounced & prev.
REQ-013 press_pulse SHALL be 1 for exactly the cycle after every edge at which rise=1, in every FSM state.
REQ-014 FSM states SHALL be IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; WAIT_SECOND and SECOND_PRESSED exist only with the macro.
REQ-015 IDLE: on rise -> PRESSED with counter cleared to 0; otherwise stay.
REQ-016 PRESSED: counter increments by 1 each cycle while pb_debounced=1.
REQ-017 PRESSED: when counter = LONG_CYCLES-1 and pb_debounced=1 -> LONG_HELD; long_press pulses the cycle after that edge.
REQ-018 PRESSED: on fall before the long threshold -> short-release handling (REQ-024/REQ-027).
REQ-019 LONG_HELD: held=1; on fall -> IDLE with no further pulse.
REQ-020 The counter SHALL be clog2(max(LONG_CYCLES, DBL_GAP_CYCLES)) bits wide, SHALL saturate rather than wrap, and SHALL clear on every state change.
REQ-021 At most one of short_press, long_press, double_click SHALL be high in any cycle.
REQ-022 Each press SHALL produce exactly one classification pulse, or none if interrupted by reset.

Reset
REQ-023 While rst_n=0: state IDLE, counter 0, all outputs 0, prev = 1.
REQ-023a Because prev resets to 1, a button held through reset release produces no event until it is released and pressed again.
REQ-023b Asserting reset mid-press SHALL discard the press; no pulse is emitted for it.

Configuration
REQ-024 Without DOUBLE_CLICK_EN: fall in PRESSED -> IDLE, with short_press pulsed the cycle after the fall edge; double_click is constant 0.
REQ-025 With DOUBLE_CLICK_EN: fall in PRESSED -> WAIT_SECOND with counter cleared; counter increments each cycle in WAIT_SECOND.
REQ-026 WAIT_SECOND: on rise before counter = DBL_GAP_CYCLES-1 -> SECOND_PRESSED; press_pulse still fires.
REQ-027 WAIT_SECOND: when counter reaches DBL_GAP_CYCLES-1 without a rise -> IDLE, with short_press pulsed the next cycle.
REQ-027a If the rise and the timeout occur on the same edge, the rise SHALL win.
REQ-028 SECOND_PRESSED: on fall -> IDLE, with double_click pulsed the next cycle; second-press duration is ignored and no long_press is issued.

Verification (bench: LONG_CYCLES=8, DBL_GAP_CYCLES=5)
REQ-029 Macro off, press 3 cycles then release -> press_pulse once at the press; short_press once, the cycle after the fall edge; no long_press.
REQ-030 Press held 20 cycles -> long_press exactly once, 8 cycles after the press edge; held=1 until release; no short_press at release.
REQ-031 Macro on, press 2 cycles, release 2 cycles, press 2 cycles, release -> press_pulse twice; double_click once after the final fall; short_press never.
REQ-032 Macro on, press 2 cycles, then release for 10 cycles -> short_press exactly once, 5 cycles after the fall; double_click never.
REQ-033 pb_debounced=1 before rst_n rises and held 30 cycles -> no output activity; a later release and re-press behaves normally.
REQ-034 rst_n pulsed low at cycle 4 of an 8-cycle hold -> all outputs 0 immediately; no short_press or long_press for that press.

Source files
------------

// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : press_classifier
// Description : Classifies debounced button presses as short, long or double
//               click. The double-click path is compiled in by DOUBLE_CLICK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module press_classifier #(
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int DBL_GAP_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > DBL_GAP_CYCLES) ? LONG_CYCLES : DBL_GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2
`ifdef DOUBLE_CLICK_EN
    ,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             prev_q, prev_d;
  logic             press_pulse_q, press_pulse_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             held_q, held_d;
  logic             count_inc;
  logic             rise;
  logic             fall;
`ifdef DOUBLE_CLICK_EN
  logic             double_click_q, double_click_d;
`endif

  assign rise = pb_debounced & ~prev_q;
  assign fall = ~pb_debounced & prev_q;

  always_comb begin
    state_d       = state_q;
    count_inc     = 1'b0;
    short_press_d = 1'b0;
    long_press_d  = 1'b0;
`ifdef DOUBLE_CLICK_EN
    double_click_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
`ifdef DOUBLE_CLICK_EN
          state_d = WAIT_SECOND;
`else
          state_d       = IDLE;
          short_press_d = 1'b1;
`endif
        end else if (count_q == LONG_LAST) begin
          state_d      = LONG_HELD;
          long_press_d = 1'b1;
        end else begin
          count_inc = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) state_d = IDLE;
      end
`ifdef DOUBLE_CLICK_EN
      WAIT_SECOND: begin
        // A rise on the same edge as the timeout still counts as a double click
        if (rise) begin
          state_d = SECOND_PRESSED;
        end else if (count_q == GAP_LAST) begin
          state_d       = IDLE;
          short_press_d = 1'b1;
        end else begin
          count_inc = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_d        = IDLE;
          double_click_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)
      count_d = '0;
    else if (count_inc && (count_q != CNT_MAX))
      count_d = count_q + 1'b1;
    else
      count_d = count_q;

    prev_d        = pb_debounced;
    press_pulse_d = rise;
    held_d        = (state_d == LONG_HELD);
  end

  // prev resets high so a button held across reset release is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      prev_q        <= 1'b1;
      press_pulse_q <= 1'b0;
      short_press_q <= 1'b0;
      long_press_q  <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      prev_q        <= prev_d;
      press_pulse_q <= press_pulse_d;
      short_press_q <= short_press_d;
      long_press_q  <= long_press_d;
      held_q        <= held_d;
    end
  end

`ifdef DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) double_click_q <= 1'b0;
    else        double_click_q <= double_click_d;
  end
  assign double_click = double_click_q;
`else
  assign double_click = 1'b0;
`endif

  assign press_pulse = press_pulse_q;
  assign short_press = short_press_q;
  assign long_press  = long_press_q;
  assign held        = held_q;

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_classifier
// Description : Directed scoreboard bench for press_classifier, with
//               expectations for both DOUBLE_CLICK_EN settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_classifier;

  localparam int LONG_CYCLES    = 8;
  localparam int DBL_GAP_CYCLES = 5;

  localparam int K_DBL   = 0;
  localparam int K_LONG  = 1;
  localparam int K_SHORT = 2;
  localparam int K_PRESS = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic pb;
  logic press_pulse, short_press, long_press, double_click, held;

  typedef struct {
    int e;
    int k;
  } ev_t;

  ev_t   sb[$];
  int    edge_n  = 0;
  int    total   = 0;
  int    bad     = 0;
  int    hold_lo = 1_000_000;
  int    hold_hi = -1;
  string scen    = "reset";
  int    e;

  press_classifier #(
    .LONG_CYCLES    (LONG_CYCLES),
    .DBL_GAP_CYCLES (DBL_GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_debounced (pb),
    .press_pulse  (press_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input int kind);
    ev_t x;
    x.e = at;
    x.k = kind;
    sb.push_back(x);
  endtask

  task automatic tick();
    logic [3:0] exp_v;
    logic       exp_h;
    @(posedge clk);
    edge_n++;
    #1;
    exp_v = 4'b0000;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].e == edge_n) begin
        exp_v[sb[i].k] = 1'b1;
        sb.delete(i);
      end
    end
    exp_h = (edge_n >= hold_lo) && (edge_n <= hold_hi);
    chk($sformatf("%s@%0d pulses{p,s,l,d}", scen, edge_n),
        {4'b0, press_pulse, short_press, long_press, double_click}, {4'b0, exp_v});
    chk($sformatf("%s@%0d held", scen, edge_n), {7'b0, held}, {7'b0, exp_h});
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pb = v;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {3'b0, press_pulse, short_press, long_press, double_click, held}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 3);

    // Short press of 3 cycles
    scen = "short3";
    e = edge_n;
    push(e + 1, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 9, K_SHORT);
`else
    push(e + 4, K_SHORT);
`endif
    drive(1, 3);
    drive(0, 10);

    // Long press held 20 cycles
    scen = "long20";
    e = edge_n;
    push(e + 1, K_PRESS);
    push(e + 9, K_LONG);
    hold_lo = e + 9;
    hold_hi = e + 20;
    drive(1, 20);
    drive(0, 10);

    // Held for 8 edges: one short of the long threshold
    scen = "hold8";
    e = edge_n;
    push(e + 1, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 14, K_SHORT);
`else
    push(e + 9, K_SHORT);
`endif
    drive(1, 8);
    drive(0, 10);

    // Double click
    scen = "dbl";
    e = edge_n;
    push(e + 1, K_PRESS);
    push(e + 5, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 7, K_DBL);
`else
    push(e + 3, K_SHORT);
    push(e + 7, K_SHORT);
`endif
    drive(1, 2);
    drive(0, 2);
    drive(1, 2);
    drive(0, 10);

    // Release long enough for the gap to expire
    scen = "gap_timeout";
    e = edge_n;
    push(e + 1, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 8, K_SHORT);
`else
    push(e + 3, K_SHORT);
`endif
    drive(1, 2);
    drive(0, 10);

    // Re-press on the very edge the gap expires: rise wins
    scen = "gap_tie";
    e = edge_n;
    push(e + 1, K_PRESS);
    push(e + 8, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 10, K_DBL);
`else
    push(e + 3, K_SHORT);
    push(e + 10, K_SHORT);
`endif
    drive(1, 2);
    drive(0, 5);
    drive(1, 2);
    drive(0, 10);

    // Re-press one edge after the gap expired: two separate presses
    scen = "gap_late";
    e = edge_n;
    push(e + 1, K_PRESS);
    push(e + 9, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 8, K_SHORT);
    push(e + 16, K_SHORT);
`else
    push(e + 3, K_SHORT);
    push(e + 11, K_SHORT);
`endif
    drive(1, 2);
    drive(0, 6);
    drive(1, 2);
    drive(0, 10);

    // Button held across reset release
    scen = "held_thru_reset";
    pb    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("held_thru_reset immediate");
    tick();
    tick();
    rst_n = 1'b1;
    drive(1, 30);
    drive(0, 3);
    e = edge_n;
    push(e + 1, K_PRESS);
`ifdef DOUBLE_CLICK_EN
    push(e + 9, K_SHORT);
`else
    push(e + 4, K_SHORT);
`endif
    drive(1, 3);
    drive(0, 10);

    // Reset mid-press discards the press
    scen = "reset_mid";
    e = edge_n;
    push(e + 1, K_PRESS);
    drive(1, 4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid immediate");
    tick();
    rst_n = 1'b1;
    drive(1, 3);
    drive(0, 10);

    // Reset while in the long-held state clears held at once
    scen = "reset_held";
    e = edge_n;
    push(e + 1, K_PRESS);
    push(e + 9, K_LONG);
    hold_lo = e + 9;
    hold_hi = e + 12;
    drive(1, 12);
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_held immediate");
    tick();
    rst_n = 1'b1;
    drive(1, 3);
    drive(0, 8);

    chk("scoreboard empty", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
